// File: rtl/mem_arb2_pkg.sv
// Shared memory-port types and configuration for the two-master arbiter.
package mem_arb2_pkg;

    localparam int MEM_AW    = 32;
    localparam int MEM_DW    = 32;
    localparam int MEM_MW    = MEM_DW / 8;
    localparam int MEM_ARB_N = 2;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_op_e;

    typedef struct packed {
        mem_op_e             op;
        logic [MEM_AW-1:0]   addr;
        logic [MEM_DW-1:0]   data;
        logic [MEM_MW-1:0]   mask;
    } mem_req_t;

    typedef struct packed {
        logic [MEM_DW-1:0]   data;
    } mem_resp_t;

endpackage

// File: rtl/mem_arb2_arb.sv
// 2-way arbiter: round-robin (mode_i=1) or fixed priority with m0 winning
// (mode_i=0). last_gnt_o records the id of the most recent committed grant.
module arb_rr2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req_i,
    input  logic       en_i,
    input  logic       mode_i,
    output logic [1:0] gnt_o,
    output logic       last_gnt_o
);

    logic last_gnt_q, last_gnt_d;

    // One-hot grant; contention resolved by mode and the last winner
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11)
            gnt_o = (mode_i && !last_gnt_q) ? 2'b10 : 2'b01;
        last_gnt_d = (en_i && |gnt_o) ? gnt_o[1] : last_gnt_q;
    end

    // Last-winner register; resets to m1 so m0 is favoured first
    always_ff @(posedge clk) begin
        if (!rstn) last_gnt_q <= 1'b1;
        else       last_gnt_q <= last_gnt_d;
    end

    assign last_gnt_o = last_gnt_q;

endmodule

// File: rtl/mem_arb2.sv
// Two-master arbiter in front of a fixed 1-cycle-latency memory. Tracks the
// single in-flight access and returns its response to the owner, with a
// one-entry response buffer per master to absorb master back-pressure.
module mem_arb2
    import mem_arb2_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      m0_req_valid,
    output logic      m0_req_ready,
    input  mem_req_t  m0_req,
    output logic      m0_resp_valid,
    input  logic      m0_resp_ready,
    output mem_resp_t m0_resp,
    input  logic      m1_req_valid,
    output logic      m1_req_ready,
    input  mem_req_t  m1_req,
    output logic      m1_resp_valid,
    input  logic      m1_resp_ready,
    output mem_resp_t m1_resp,
    output logic      s_req_valid,
    input  logic      s_req_ready,
    output mem_req_t  s_req,
    input  logic      s_resp_valid,
    output logic      s_resp_ready,
    input  mem_resp_t s_resp
);

    logic [MEM_ARB_N-1:0] req_vld, resp_rdy, resp_vld, arriving, elig, gnt;
    logic [MEM_ARB_N-1:0] rbuf_vld_q, rbuf_vld_d;
    mem_resp_t            rbuf_q [MEM_ARB_N];
    mem_resp_t            rbuf_d [MEM_ARB_N];
    mem_resp_t            resp_dat [MEM_ARB_N];
    logic                 infl_vld_q, infl_vld_d;
    logic                 infl_id_q, infl_id_d;
    logic                 last_gnt, s_acc;

    assign req_vld  = {m1_req_valid, m0_req_valid};
    assign resp_rdy = {m1_resp_ready, m0_resp_ready};

    // Arrival, response view and credit-based eligibility per master.
    // Everything is gated by rstn so nothing is offered while in reset.
    always_comb begin
        for (int i = 0; i < MEM_ARB_N; i++) begin
            arriving[i] = rstn && infl_vld_q && (infl_id_q == 1'(i));
            resp_vld[i] = rstn && (rbuf_vld_q[i] || arriving[i]);
            resp_dat[i] = rbuf_vld_q[i] ? rbuf_q[i] : s_resp;
            elig[i]     = rstn && req_vld[i] && !rbuf_vld_q[i] &&
                          (!arriving[i] || resp_rdy[i]);
        end
    end

    arb_rr2 u_arb (
        .clk        (clk),
        .rstn       (rstn),
        .req_i      (elig),
        .en_i       (s_acc),
        .mode_i     (ROUND_ROBIN),
        .gnt_o      (gnt),
        .last_gnt_o (last_gnt)
    );

    assign s_req_valid   = |elig;
    assign s_req         = gnt[1] ? m1_req : m0_req;
    assign s_acc         = s_req_valid && s_req_ready;
    assign s_resp_ready  = 1'b1;
    assign m0_req_ready  = gnt[0] && s_req_ready;
    assign m1_req_ready  = gnt[1] && s_req_ready;
    assign m0_resp_valid = resp_vld[0];
    assign m1_resp_valid = resp_vld[1];
    assign m0_resp       = resp_dat[0];
    assign m1_resp       = resp_dat[1];

    // Next state: in-flight tracker and response buffers
    always_comb begin
        infl_vld_d = s_acc;
        infl_id_d  = gnt[1];
        for (int i = 0; i < MEM_ARB_N; i++) begin
            rbuf_vld_d[i] = rbuf_vld_q[i];
            rbuf_d[i]     = rbuf_q[i];
            if (arriving[i] && !rbuf_vld_q[i] && !resp_rdy[i]) begin
                rbuf_vld_d[i] = 1'b1;
                rbuf_d[i]     = s_resp;
            end else if (resp_vld[i] && resp_rdy[i]) begin
                rbuf_vld_d[i] = 1'b0;
            end
        end
    end

    // State registers; reset drops any in-flight or buffered response
    always_ff @(posedge clk) begin
        if (!rstn) begin
            infl_vld_q <= 1'b0;
            infl_id_q  <= 1'b0;
            rbuf_vld_q <= '0;
            for (int i = 0; i < MEM_ARB_N; i++) rbuf_q[i] <= '0;
        end else begin
            infl_vld_q <= infl_vld_d;
            infl_id_q  <= infl_id_d;
            rbuf_vld_q <= rbuf_vld_d;
            for (int i = 0; i < MEM_ARB_N; i++) rbuf_q[i] <= rbuf_d[i];
        end
    end

    // A memory response with nothing outstanding is a memory-side bug
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rstn)
        !(s_resp_valid && !infl_vld_q));

    // The credit rule must keep a full buffer from ever seeing an arrival
    a_no_rbuf0_ovwr: assert property (@(posedge clk) disable iff (!rstn)
        !(arriving[0] && rbuf_vld_q[0]));
    a_no_rbuf1_ovwr: assert property (@(posedge clk) disable iff (!rstn)
        !(arriving[1] && rbuf_vld_q[1]));

    // The arbiter's last winner always names the in-flight owner
    a_owner_match: assert property (@(posedge clk) disable iff (!rstn)
        infl_vld_q |-> (last_gnt == infl_id_q));

endmodule
